// File: rtl/seg_msg_checker.sv
// Receive end of the stepped 7-segment message display: samples the segment bus on
// debounced strobe edges, decodes each pattern and checks the frame 80,"SEnOLGULGOnUL".
// Latency: char_code/char_valid at E+SETTLE+1, frame status at E+SETTLE+2 (E = accepted edge).
module seg_msg_checker #(
   parameter int DEBOUNCE = 1000,
   parameter int SETTLE   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seg_in,
   input  logic       seg_stb,
   output logic [3:0] char_code,
   output logic       char_valid,
   output logic [3:0] pos,
   output logic       in_frame,
   output logic       err,
   output logic       msg_ok,
   output logic [7:0] msg_count,
   output logic [7:0] err_count
);

   localparam int LW = $clog2(DEBOUNCE + 1);
   localparam int SW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   // Segment pattern to character code; anything not in the alphabet is 4'hF.
   function automatic logic [3:0] decode(input logic [7:0] seg);
      case (seg)
         8'h80:   decode = 4'h0;
         8'h5B:   decode = 4'h1;
         8'h4F:   decode = 4'h2;
         8'h15:   decode = 4'h3;
         8'h7E:   decode = 4'h4;
         8'h0E:   decode = 4'h5;
         8'h5F:   decode = 4'h6;
         8'h3E:   decode = 4'h7;
         8'h00:   decode = 4'hE;
         default: decode = 4'hF;
      endcase
   endfunction

   // Character expected at each frame position 1..13.
   function automatic logic [3:0] exp_code(input logic [3:0] p);
      case (p)
         4'd1:    exp_code = 4'h1;
         4'd2:    exp_code = 4'h2;
         4'd3:    exp_code = 4'h3;
         4'd4:    exp_code = 4'h4;
         4'd5:    exp_code = 4'h5;
         4'd6:    exp_code = 4'h6;
         4'd7:    exp_code = 4'h7;
         4'd8:    exp_code = 4'h5;
         4'd9:    exp_code = 4'h6;
         4'd10:   exp_code = 4'h4;
         4'd11:   exp_code = 4'h3;
         4'd12:   exp_code = 4'h7;
         4'd13:   exp_code = 4'h5;
         default: exp_code = 4'hF;
      endcase
   endfunction

   logic          stb_s1_q, stb_s2_q, stb_s3_q;
   logic [7:0]    seg_s1_q, seg_s2_q;
   logic [LW-1:0] lockout_q;
   logic [SW-1:0] settle_q;
   logic [3:0]    code_q;
   logic          code_vld_q;
   state_t        state_q, state_d;
   logic [3:0]    pos_q, pos_d;
   logic          err_q, err_d;
   logic          msg_ok_q, msg_ok_d;
   logic [7:0]    msg_cnt_q, msg_cnt_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          stb_acc;
   logic          capture;
   logic          code_match;

   // Two-flop synchronizers for strobe and segment bus, plus a strobe history flop for edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         stb_s1_q <= 1'b0;
         stb_s2_q <= 1'b0;
         stb_s3_q <= 1'b0;
         seg_s1_q <= 8'h00;
         seg_s2_q <= 8'h00;
      end else begin
         stb_s1_q <= seg_stb;
         stb_s2_q <= stb_s1_q;
         stb_s3_q <= stb_s2_q;
         seg_s1_q <= seg_in;
         seg_s2_q <= seg_s1_q;
      end
   end

   // Rising edge is only honoured once the previous lockout has fully expired.
   assign stb_acc = stb_s2_q & ~stb_s3_q & (lockout_q == '0);
   assign capture = (settle_q == SW'(1));

   // Lockout and settle counters; SETTLE < DEBOUNCE keeps a single capture in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         lockout_q <= '0;
         settle_q  <= '0;
      end else begin
         if (stb_acc)
            lockout_q <= LW'(DEBOUNCE);
         else if (lockout_q != '0)
            lockout_q <= lockout_q - LW'(1);
         if (stb_acc)
            settle_q <= SW'(SETTLE);
         else if (settle_q != '0)
            settle_q <= settle_q - SW'(1);
      end
   end

   // Decode the settled segment bus into the character register.
   always_ff @(posedge clk) begin
      if (rst) begin
         code_q     <= 4'h0;
         code_vld_q <= 1'b0;
      end else begin
         code_vld_q <= capture;
         if (capture)
            code_q <= decode(seg_s2_q);
      end
   end

   assign code_match = (code_q == exp_code(pos_q));

   // Frame checker state and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pos_q     <= 4'd0;
         err_q     <= 1'b0;
         msg_ok_q  <= 1'b0;
         msg_cnt_q <= 8'h00;
         err_cnt_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         err_q     <= err_d;
         msg_ok_q  <= msg_ok_d;
         msg_cnt_q <= msg_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Next-state selection on each decoded character.
   always_comb begin
      state_d = state_q;
      if (code_vld_q) begin
         case (state_q)
            ST_IDLE:  if (code_q == 4'h0) state_d = ST_CHECK;
            ST_CHECK: begin
               if (code_match) begin
                  if (pos_q == 4'd13) state_d = ST_IDLE;
               end else if (code_q != 4'h0) begin
                  state_d = ST_ERROR;
               end
            end
            ST_ERROR: if (code_q == 4'h0) state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Position, error flag, pulse and saturating counter updates.
   always_comb begin
      pos_d     = pos_q;
      err_d     = err_q;
      msg_ok_d  = 1'b0;
      msg_cnt_d = msg_cnt_q;
      err_cnt_d = err_cnt_q;
      if (code_vld_q) begin
         case (state_q)
            ST_CHECK: begin
               if (code_match) begin
                  if (pos_q == 4'd13) begin
                     msg_ok_d  = 1'b1;
                     msg_cnt_d = (msg_cnt_q == 8'hFF) ? msg_cnt_q : msg_cnt_q + 8'd1;
                     pos_d     = 4'd0;
                  end else begin
                     pos_d = pos_q + 4'd1;
                  end
               end else begin
                  // Early start marker abandons the frame as bad but opens a new one.
                  err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                  if (code_q == 4'h0) begin
                     pos_d = 4'd1;
                     err_d = 1'b0;
                  end else begin
                     pos_d = 4'd0;
                     err_d = 1'b1;
                  end
               end
            end
            ST_IDLE, ST_ERROR: begin
               if (code_q == 4'h0) begin
                  pos_d = 4'd1;
                  err_d = 1'b0;
               end
            end
            default: pos_d = 4'd0;
         endcase
      end
   end

   assign char_code  = code_q;
   assign char_valid = code_vld_q;
   assign pos        = pos_q;
   assign in_frame   = (state_q == ST_CHECK);
   assign err        = err_q;
   assign msg_ok     = msg_ok_q;
   assign msg_count  = msg_cnt_q;
   assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_seg_msg_checker.sv
// Bench for seg_msg_checker: directed frames, bounce, reset and saturation plus random characters.
// Every character is compared against a frame-level reference model kept here.
module tb_seg_msg_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] seg_in;
   logic       seg_stb;
   logic [3:0] char_code;
   logic       char_valid;
   logic [3:0] pos;
   logic       in_frame;
   logic       err;
   logic       msg_ok;
   logic [7:0] msg_count;
   logic [7:0] err_count;

   seg_msg_checker #(.DEBOUNCE(10), .SETTLE(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_in     (seg_in),
      .seg_stb    (seg_stb),
      .char_code  (char_code),
      .char_valid (char_valid),
      .pos        (pos),
      .in_frame   (in_frame),
      .err        (err),
      .msg_ok     (msg_ok),
      .msg_count  (msg_count),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cv_seen = 0;
   int ok_seen = 0;

   // Pulse counters, sampled on the falling edge.
   always @(negedge clk) begin
      if (char_valid) cv_seen++;
      if (msg_ok)     ok_seen++;
   end

   // Reference model state.
   logic [7:0] pat_tab [9] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E, 8'h00};
   int         cod_tab [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 14};
   logic [7:0] frame_seg [14] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
                                  8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E};
   int         frame_code [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 5, 6, 4, 3, 7, 5};
   int m_code, m_cv, m_ok, m_pos, m_msg, m_errc;
   bit m_frame, m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_decode(input logic [7:0] s);
      int c = 15;
      for (int i = 0; i < 9; i++)
         if (pat_tab[i] == s) c = cod_tab[i];
      return c;
   endfunction

   task automatic model_reset();
      m_code = 0; m_pos = 0; m_msg = 0; m_errc = 0; m_frame = 0; m_err = 0;
   endtask

   // One received character applied to the frame rules.
   task automatic model_step(input int c);
      m_cv++;
      m_code = c;
      if (!m_frame) begin
         if (c == 0) begin m_frame = 1; m_pos = 1; m_err = 0; end
      end else if (c == frame_code[m_pos]) begin
         if (m_pos == 13) begin
            m_ok++; m_pos = 0; m_frame = 0;
            if (m_msg < 255) m_msg++;
         end else m_pos++;
      end else begin
         if (m_errc < 255) m_errc++;
         if (c == 0) m_pos = 1;
         else begin m_err = 1; m_pos = 0; m_frame = 0; end
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".code"},  32'(char_code), 32'(m_code));
      check({tag, ".cv"},    32'(cv_seen),   32'(m_cv));
      check({tag, ".ok"},    32'(ok_seen),   32'(m_ok));
      check({tag, ".pos"},   32'(pos),       32'(m_pos));
      check({tag, ".infr"},  32'(in_frame),  32'(m_frame));
      check({tag, ".err"},   32'(err),       32'(m_err));
      check({tag, ".msgc"},  32'(msg_count), 32'(m_msg));
      check({tag, ".errc"},  32'(err_count), 32'(m_errc));
   endtask

   // One clean strobe with a stable segment byte; 14 cycles covers capture and lockout.
   task automatic send_char(input logic [7:0] s, input string tag);
      seg_in  = s;
      seg_stb = 1'b1;
      cycles(3);
      seg_stb = 1'b0;
      cycles(11);
      model_step(model_decode(s));
      check_all(tag);
   endtask

   task automatic do_reset();
      seg_stb = 1'b0;
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      model_reset();
      cycles(1);
   endtask

   task automatic send_frame(input string tag);
      for (int i = 0; i < 14; i++) send_char(frame_seg[i], tag);
   endtask

   initial begin
      logic [7:0] s;
      int r;
      m_cv = 0; m_ok = 0;
      seg_in = 8'h00;
      seg_stb = 1'b0;
      do_reset();
      check_all("reset");

      // Clean frame.
      send_frame("t1");
      check("t1.msg_count", 32'(msg_count), 32'd1);

      // Bouncing strobe: five rising edges inside the lockout.
      seg_in = 8'h5B;
      for (int i = 0; i < 5; i++) begin
         seg_stb = 1'b1; cycles(1);
         seg_stb = 1'b0; cycles(1);
      end
      cycles(14);
      model_step(1);
      check_all("t2");
      check("t2.code", 32'(char_code), 32'd1);

      // Mismatch, ignored chars in error, recovery on start marker.
      send_char(8'h80, "t3a"); send_char(8'h5B, "t3b"); send_char(8'h4F, "t3c");
      send_char(8'h0E, "t3d");
      check("t3.err", 32'(err), 32'd1);
      send_char(8'h5B, "t3e"); send_char(8'h4F, "t3f");
      send_char(8'h80, "t3g");
      check("t3.pos", 32'(pos), 32'd1);

      // Unknown and blank patterns outside a frame.
      send_char(8'h0E, "t3h");
      send_char(8'h3E, "t3i");
      send_char(8'hFF, "t4a");
      send_char(8'h00, "t4b");
      check("t4.code", 32'(char_code), 32'hE);

      // Randomized characters, biased toward progressing frames.
      for (int k = 0; k < 200; k++) begin
         r = $urandom_range(0, 9);
         if (r < 6 && m_frame) s = frame_seg[m_pos];
         else if (r < 8)       s = 8'h80;
         else if (r == 8)      s = pat_tab[$urandom_range(0, 8)];
         else                  s = 8'($urandom_range(0, 255));
         send_char(s, "rnd");
      end

      // Reset in the middle of a frame, landing inside the settle window.
      do_reset();
      for (int i = 0; i < 6; i++) send_char(frame_seg[i], "t5pre");
      seg_in  = 8'h5F;
      seg_stb = 1'b1;
      cycles(3);
      seg_stb = 1'b0;
      rst = 1'b1;
      cycles(5);
      model_reset();
      check_all("t5rst");
      rst = 1'b0;
      cycles(14);
      check_all("t5post");
      send_frame("t5");
      check("t5.msg_count", 32'(msg_count), 32'd1);

      // Saturation of the good-frame counter, then a double start marker.
      do_reset();
      for (int f = 0; f < 257; f++) send_frame("t6");
      check("t6.msg_sat", 32'(msg_count), 32'd255);
      send_char(8'h80, "t6a");
      send_char(8'h80, "t6b");
      check("t6.errc", 32'(err_count), 32'd1);
      check("t6.pos",  32'(pos),       32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
